bias_rd_ctrl: RTL and testbench

// - Read sequencer for the bias ROM stage; drives addr_rd / bias_out_valid / BiasMem_valid_out / state_rst of BiasMemoryTop.
// - Armed when the global FSM enters ACTIVE_STATE; issues GRP_CNT consecutive ROM addresses from BASE_ADDR on consumer requests.
// - Tracks the 2-cycle address->data latency; pulses state_rst once the last bias word is delivered.

---
 rtl/bias_rd_ctrl_pkg.sv | 24 ++
 rtl/bias_rd_ctrl_if.sv | 30 +++
 rtl/bias_rd_ctrl.sv | 99 +++++++++
 tb/tb_bias_rd_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bias_rd_ctrl_pkg.sv
// Shared definitions for the bias ROM read path: global FSM encodings,
// bias sequencer state type and bias memory geometry.
package bias_rd_ctrl_pkg;

  // Global controller FSM
  localparam int               GLB_STATE_W   = 3;
  localparam logic [2:0]       GLB_IDLE      = 3'd0;
  localparam logic [2:0]       GLB_LOAD      = 3'd1;
  localparam logic [2:0]       GLB_ACTIVE    = 3'd2;
  localparam logic [2:0]       GLB_WRITEBACK = 3'd3;
  localparam logic [2:0]       GLB_ERROR     = 3'd7;

  // Bias memory geometry
  localparam int BIAS_ADDR_W        = 9;
  localparam int BIAS_CHANNEL_WIDTH = 288;

  typedef enum logic [1:0] {
    BIAS_IDLE  = 2'd0,
    BIAS_ISSUE = 2'd1,
    BIAS_DRAIN = 2'd2,
    BIAS_DONE  = 2'd3
  } bias_fsm_e;

endpackage

// File: rtl/bias_rd_ctrl_if.sv
// Control/handshake bundle between the bias read sequencer (master)
// and the bias memory stage / consumer (slave).
interface bias_rd_ctrl_if
  import bias_rd_ctrl_pkg::*;
#(
  parameter int ADDR_W  = BIAS_ADDR_W,
  parameter int STATE_W = GLB_STATE_W
);

  logic [STATE_W-1:0] current_state;
  logic [ADDR_W-1:0]  layer_base_addr;
  logic [ADDR_W-1:0]  layer_grp_cnt;
  logic               bias_req;
  logic [ADDR_W-1:0]  addr_rd;
  logic               bias_out_valid;
  logic               BiasMem_valid_out;
  logic               state_rst;
  logic               busy;

  modport master (
    input  current_state, layer_base_addr, layer_grp_cnt, bias_req,
    output addr_rd, bias_out_valid, BiasMem_valid_out, state_rst, busy
  );

  modport slave (
    output current_state, layer_base_addr, layer_grp_cnt, bias_req,
    input  addr_rd, bias_out_valid, BiasMem_valid_out, state_rst, busy
  );

endinterface

// File: rtl/bias_rd_ctrl.sv
// Bias ROM read sequencer: armed on entry to the active global state, issues
// one address per consumer request and tracks the 2-cycle ROM latency.
module bias_rd_ctrl
  import bias_rd_ctrl_pkg::*;
#(
  parameter int                 RD_ADDR_DEPTH = BIAS_ADDR_W,
  parameter int                 STATE_W       = GLB_STATE_W,
  parameter logic [STATE_W-1:0] ACTIVE_STATE  = GLB_ACTIVE
) (
  input  logic           clk,
  input  logic           rstn,
  bias_rd_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE  = BIAS_IDLE;
  localparam logic [1:0] S_ISSUE = BIAS_ISSUE;
  localparam logic [1:0] S_DRAIN = BIAS_DRAIN;
  localparam logic [1:0] S_DONE  = BIAS_DONE;

  logic [1:0]               state;
  logic [STATE_W-1:0]       prev_state;
  logic [RD_ADDR_DEPTH-1:0] base_q;
  logic [RD_ADDR_DEPTH-1:0] cnt_q;
  logic [RD_ADDR_DEPTH-1:0] idx;
  logic [RD_ADDR_DEPTH-1:0] idx_nxt;
  logic [RD_ADDR_DEPTH-1:0] addr_q;
  // vpipe[0]: address issued last edge; vpipe[1]: ROM data valid this cycle
  logic [1:0]               vpipe;
  logic                     in_active;
  logic                     arm;

  assign in_active = (bus.current_state == ACTIVE_STATE);
  assign arm       = in_active && (prev_state != ACTIVE_STATE);
  assign idx_nxt   = idx + RD_ADDR_DEPTH'(1);

  // NOTE: every register is updated with <= so all reads in this block see
  // pre-edge values; mixing in = here would make order-dependent logic.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      prev_state <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      idx        <= '0;
      addr_q     <= '0;
      vpipe      <= '0;
    end else begin
      prev_state <= bus.current_state;
      case (state)
        S_IDLE: begin
          vpipe <= '0;
          if (arm) begin
            base_q <= bus.layer_base_addr;
            cnt_q  <= bus.layer_grp_cnt;
            idx    <= '0;
            state  <= (bus.layer_grp_cnt == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!in_active) begin
            state <= S_IDLE;
            vpipe <= '0;
          end else begin
            vpipe <= {vpipe[0], bus.bias_req};
            if (bus.bias_req) begin
              // Sum truncates to RD_ADDR_DEPTH bits: wraps past the top of the ROM
              addr_q <= base_q + idx;
              idx    <= idx_nxt;
              if (idx_nxt == cnt_q) state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!in_active) begin
            state <= S_IDLE;
            vpipe <= '0;
          end else begin
            vpipe <= {vpipe[0], 1'b0};
            // Leave once the last word moves into the output stage, so the
            // completion pulse lands in the cycle right after the final valid.
            if (!vpipe[0]) state <= S_DONE;
          end
        end
        S_DONE: begin
          vpipe <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.addr_rd           = addr_q;
  assign bus.bias_out_valid    = vpipe[1];
  assign bus.BiasMem_valid_out = vpipe[1];
  assign bus.state_rst         = (state == S_DONE);
  assign bus.busy              = (state == S_ISSUE) || (state == S_DRAIN);

endmodule

// File: tb/tb_bias_rd_ctrl.sv
// Directed bench for bias_rd_ctrl: reset, contiguous, gapped, wrapping,
// zero-length and aborted layers, each with hand-computed per-cycle outputs.
module tb_bias_rd_ctrl;
  import bias_rd_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   n_vec = 0;
  int   n_err = 0;

  bias_rd_ctrl_if bus ();

  bias_rd_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic req);
    bus.bias_req = req;
    @(posedge clk);
    #1;
  endtask

  // Drop out of the active state for one edge, then enter it with new layer info
  task automatic arm_layer(input logic [8:0] base, input logic [8:0] cnt);
    bus.current_state = GLB_IDLE;
    tick(1'b0);
    bus.current_state   = GLB_ACTIVE;
    bus.layer_base_addr = base;
    bus.layer_grp_cnt   = cnt;
    tick(1'b0);
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy, bus.addr_rd} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_por: got v/vo/rst/busy/addr=%b need all zero",
               {bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy, bus.addr_rd});
    end
    #11 rstn = 1'b1;
    tick(1'b0);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b need 0", bus.busy);
    end
    // Reset in the middle of an issue burst
    arm_layer(9'd20, 9'd5);
    tick(1'b1);
    tick(1'b1);
    n_vec++;
    if ({bus.bias_out_valid, bus.busy, bus.addr_rd} !== {1'b1, 1'b1, 9'd21}) begin
      n_err++;
      $display("FAIL reset_pre: got v/busy/addr=%b/%b/%0d need 1/1/21",
               bus.bias_out_valid, bus.busy, bus.addr_rd);
    end
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if ({bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy, bus.addr_rd} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_async: got v/vo/rst/busy/addr=%b need all zero",
               {bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy, bus.addr_rd});
    end
    bus.current_state = GLB_IDLE;
    #2 rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      n_vec++;
      if ({bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd} !== 12'd0) begin
        n_err++;
        $display("FAIL reset_release cyc%0d: got v/rst/busy/addr=%b/%b/%b/%0d need 0/0/0/0",
                 i, bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd);
      end
    end
  endtask

  task automatic test_basic();
    bit rq[7] = '{1, 1, 1, 1, 0, 0, 0};
    bit ev[7] = '{0, 1, 1, 1, 1, 0, 0};
    bit er[7] = '{0, 0, 0, 0, 0, 1, 0};
    bit eb[7] = '{1, 1, 1, 1, 1, 0, 0};
    int ea[7] = '{10, 11, 12, 13, 13, 13, 13};
    arm_layer(9'd10, 9'd4);
    for (int i = 0; i < 7; i++) begin
      tick(rq[i]);
      n_vec++;
      if ({bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy} !== {ev[i], ev[i], er[i], eb[i]}) begin
        n_err++;
        $display("FAIL basic_flags cyc%0d: got v/vo/rst/busy=%b need %b", i,
                 {bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy},
                 {ev[i], ev[i], er[i], eb[i]});
      end
      n_vec++;
      if (bus.addr_rd !== 9'(ea[i])) begin
        n_err++;
        $display("FAIL basic_addr cyc%0d: got %0d need %0d", i, bus.addr_rd, ea[i]);
      end
    end
  endtask

  task automatic test_gapped();
    bit rq[9] = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
    bit ev[9] = '{0, 1, 0, 0, 1, 1, 0, 0, 0};
    bit er[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    bit eb[9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    int ea[9] = '{100, 100, 100, 101, 102, 102, 102, 102, 102};
    arm_layer(9'd100, 9'd3);
    for (int i = 0; i < 9; i++) begin
      tick(rq[i]);
      n_vec++;
      if ({bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy} !== {ev[i], ev[i], er[i], eb[i]}) begin
        n_err++;
        $display("FAIL gapped_flags cyc%0d: got v/vo/rst/busy=%b need %b", i,
                 {bus.bias_out_valid, bus.BiasMem_valid_out, bus.state_rst, bus.busy},
                 {ev[i], ev[i], er[i], eb[i]});
      end
      n_vec++;
      if (bus.addr_rd !== 9'(ea[i])) begin
        n_err++;
        $display("FAIL gapped_addr cyc%0d: got %0d need %0d", i, bus.addr_rd, ea[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit rq[7] = '{1, 1, 1, 1, 0, 0, 0};
    bit ev[7] = '{0, 1, 1, 1, 1, 0, 0};
    bit er[7] = '{0, 0, 0, 0, 0, 1, 0};
    int ea[7] = '{510, 511, 0, 1, 1, 1, 1};
    arm_layer(9'd510, 9'd4);
    for (int i = 0; i < 7; i++) begin
      tick(rq[i]);
      n_vec++;
      if ({bus.bias_out_valid, bus.state_rst} !== {ev[i], er[i]}) begin
        n_err++;
        $display("FAIL wrap_flags cyc%0d: got v/rst=%b need %b", i,
                 {bus.bias_out_valid, bus.state_rst}, {ev[i], er[i]});
      end
      n_vec++;
      if (bus.addr_rd !== 9'(ea[i])) begin
        n_err++;
        $display("FAIL wrap_addr cyc%0d: got %0d need %0d", i, bus.addr_rd, ea[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    bit er[3] = '{1, 0, 0};
    arm_layer(9'd50, 9'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(1'b1);
      n_vec++;
      if ({bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd} !== {1'b0, er[i], 1'b0, 9'd1}) begin
        n_err++;
        $display("FAIL zero_cnt cyc%0d: got v/rst/busy/addr=%b/%b/%b/%0d need 0/%b/0/1", i,
                 bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd, er[i]);
      end
    end
  endtask

  task automatic test_abort();
    bit ev[7] = '{0, 1, 1, 0, 0, 0, 0};
    bit eb[7] = '{1, 1, 1, 0, 0, 0, 0};
    int ea[7] = '{200, 201, 202, 202, 202, 202, 202};
    bit rq2[5] = '{1, 1, 0, 0, 0};
    bit ev2[5] = '{0, 1, 1, 0, 0};
    bit er2[5] = '{0, 0, 0, 1, 0};
    bit eb2[5] = '{1, 1, 1, 0, 0};
    int ea2[5] = '{0, 1, 1, 1, 1};
    arm_layer(9'd200, 9'd8);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) bus.current_state = GLB_WRITEBACK;
      tick(1'b1);
      n_vec++;
      if ({bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd} !== {ev[i], 1'b0, eb[i], 9'(ea[i])}) begin
        n_err++;
        $display("FAIL abort cyc%0d: got v/rst/busy/addr=%b/%b/%b/%0d need %b/0/%b/%0d", i,
                 bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd, ev[i], eb[i], ea[i]);
      end
    end
    arm_layer(9'd0, 9'd2);
    for (int i = 0; i < 5; i++) begin
      tick(rq2[i]);
      n_vec++;
      if ({bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd} !== {ev2[i], er2[i], eb2[i], 9'(ea2[i])}) begin
        n_err++;
        $display("FAIL rearm cyc%0d: got v/rst/busy/addr=%b/%b/%b/%0d need %b/%b/%b/%0d", i,
                 bus.bias_out_valid, bus.state_rst, bus.busy, bus.addr_rd,
                 ev2[i], er2[i], eb2[i], ea2[i]);
      end
    end
  endtask

  initial begin
    rstn                = 1'b0;
    bus.current_state   = GLB_IDLE;
    bus.layer_base_addr = '0;
    bus.layer_grp_cnt   = '0;
    bus.bias_req        = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_wrap();
    test_zero_count();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, need completion", $time);
    $fatal(1, "timeout");
  end

endmodule
